// File: rtl/demux_gates_pkg.sv
// Shared types and helpers for the demux-built gate family.
package demux_gates_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of serial beats needed to walk a word of the given width.
  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/demux_1to2_cell.sv
// 1-to-2 demux cell: routes din to y0 when sel=0, to y1 when sel=1.
module demux_1to2_cell (
  input  logic din,
  input  logic sel,
  output logic y0,
  output logic y1
);

  assign y0 = sel ? 1'b0 : din;
  assign y1 = sel ? din  : 1'b0;

endmodule

// File: rtl/demux_parity_engine.sv
// Serial XOR/XNOR-reduce engine, LANES bits per cycle, valid/ready on both
// sides. Every parity toggle is built from demux_1to2_cell pairs: one cell
// passes acc when the data bit is 0, the other passes ~acc when it is 1,
// and their outputs are ORed.
// Optional checker mode: define DEMUX_PARITY_CHECK_EN to add in_parity and
// parity_err.
module demux_parity_engine
  import demux_gates_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef DEMUX_PARITY_CHECK_EN
  input  logic             in_parity,
  output logic             parity_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_xor,
  output logic             out_xnor,
  output logic             busy
);

  localparam int BEATS = beats(WIDTH, LANES);
  localparam int CW    = $clog2(BEATS + 1);

  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
    $error("demux_parity_engine: LANES must divide WIDTH and both must be >= 1");
  end

  state_t           state;
  logic             acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;

  // Toggle chain: chain[l+1] = sreg[l] ? ~chain[l] : chain[l]
  logic [LANES:0]   chain;
  logic [LANES-1:0] nchain;
  logic [LANES-1:0] keep_y0, flip_y1;
  logic [LANES-1:0] unused_keep_y1, unused_flip_y0;
  logic             acc_next;

  assign chain[0] = acc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign nchain[l] = ~chain[l];

    demux_1to2_cell u_keep (
      .din (chain[l]),
      .sel (sreg[l]),
      .y0  (keep_y0[l]),
      .y1  (unused_keep_y1[l])
    );

    demux_1to2_cell u_flip (
      .din (nchain[l]),
      .sel (sreg[l]),
      .y0  (unused_flip_y0[l]),
      .y1  (flip_y1[l])
    );

    assign chain[l+1] = keep_y0[l] | flip_y1[l];
  end

  assign acc_next = chain[LANES];

`ifdef DEMUX_PARITY_CHECK_EN
  // Checker: final parity toggled once more by the captured parity bit.
  logic par_cap;
  logic nacc_next;
  logic pe_keep, pe_flip, unused_pe_k, unused_pe_f;
  logic perr_next;

  assign nacc_next = ~acc_next;

  demux_1to2_cell u_pe_keep (
    .din (acc_next),
    .sel (par_cap),
    .y0  (pe_keep),
    .y1  (unused_pe_k)
  );

  demux_1to2_cell u_pe_flip (
    .din (nacc_next),
    .sel (par_cap),
    .y0  (unused_pe_f),
    .y1  (pe_flip)
  );

  assign perr_next = pe_keep | pe_flip;

  // Capture the parity bit with the word; register the verdict on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_cap    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid)
        par_cap <= in_parity;
      if (state == SHIFT && cnt == CW'(BEATS - 1))
        parity_err <= perr_next;
    end
  end
`else
  // Generator-only build: no parity input and no checker logic.
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Main FSM: capture, shift LANES bits per beat, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 1'b0;
      cnt       <= '0;
      sreg      <= '0;
      out_valid <= 1'b0;
      out_xor   <= 1'b0;
      out_xnor  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= in_data;
            acc   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc  <= acc_next;
          sreg <= sreg >> LANES;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(BEATS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_xor   <= acc_next;
            out_xnor  <= ~acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_parity_engine.sv
// Scoreboard bench for demux_parity_engine: one LANES=1 and one LANES=4
// instance, directed words with hand-computed parity. Stimulus pushes the
// expected result; per-instance monitors pop on each out_valid rise.
module tb_demux_parity_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv1 = 0, ir1, ov1, or1 = 1, ox1, oxn1, bz1, ip1 = 0, pe1;
  logic [7:0] id1 = '0;
  logic       iv4 = 0, ir4, ov4, or4 = 1, ox4, oxn4, bz4, ip4 = 0, pe4;
  logic [7:0] id4 = '0;

  demux_parity_engine #(.WIDTH(8), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
`ifdef DEMUX_PARITY_CHECK_EN
    .in_parity(ip1), .parity_err(pe1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_xor(ox1), .out_xnor(oxn1), .busy(bz1)
  );

  demux_parity_engine #(.WIDTH(8), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
`ifdef DEMUX_PARITY_CHECK_EN
    .in_parity(ip4), .parity_err(pe4),
`endif
    .out_valid(ov4), .out_ready(or4), .out_xor(ox4), .out_xnor(oxn4), .busy(bz4)
  );

`ifndef DEMUX_PARITY_CHECK_EN
  assign pe1 = 1'b0;
  assign pe4 = 1'b0;
`endif

  typedef struct {
    logic x;
    int   rise;
    logic pe;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor for the LANES=1 instance.
  logic pv1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ov1 && !pv1) begin
      if (q1.size() == 0) begin
        chk("unexpected_valid1", 32'(ov1), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("xor1",  32'(ox1),  32'(e.x));
        chk("xnor1", 32'(oxn1), 32'(!e.x));
        chk("lat1",  32'(cyc),  32'(e.rise));
`ifdef DEMUX_PARITY_CHECK_EN
        chk("perr1", 32'(pe1),  32'(e.pe));
`endif
      end
    end
    pv1 <= ov1;
  end

  // Monitor for the LANES=4 instance.
  logic pv4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ov4 && !pv4) begin
      if (q4.size() == 0) begin
        chk("unexpected_valid4", 32'(ov4), 32'd0);
      end else begin
        e = q4.pop_front();
        chk("xor4",  32'(ox4),  32'(e.x));
        chk("xnor4", 32'(oxn4), 32'(!e.x));
        chk("lat4",  32'(cyc),  32'(e.rise));
`ifdef DEMUX_PARITY_CHECK_EN
        chk("perr4", 32'(pe4),  32'(e.pe));
`endif
      end
    end
    pv4 <= ov4;
  end

  // Offer a word, wait for the accept edge, return at the following negedge.
  task automatic send(input bit w4, input logic [7:0] d, input logic par,
                      input logic ex, input bit push, input bit hold);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!(w4 ? ir4 : ir1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(w4 ? ir4 : ir1)) begin
      chk("send_timeout", 32'd0, 32'd1);
      return;
    end
    if (w4) begin iv4 = 1; id4 = d; ip4 = par; end
    else    begin iv1 = 1; id1 = d; ip1 = par; end
    @(negedge clk);
    if (!hold) begin
      if (w4) iv4 = 0;
      else    iv1 = 0;
    end
    if (push) begin
      e.x    = ex;
      e.rise = cyc + (w4 ? 2 : 8);
      e.pe   = (ex != par);
      if (w4) q4.push_back(e);
      else    q1.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0 || !ir1 || !ir4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 32'd0);
  endtask

  initial begin
    int n;
    // Reset state on both instances.
    repeat (2) @(negedge clk);
    chk("rst_in_ready1", 32'(ir1),  32'd1);
    chk("rst_valid1",    32'(ov1),  32'd0);
    chk("rst_xor1",      32'(ox1),  32'd0);
    chk("rst_xnor1",     32'(oxn1), 32'd1);
    chk("rst_busy1",     32'(bz1),  32'd0);
    chk("rst_in_ready4", 32'(ir4),  32'd1);
    chk("rst_valid4",    32'(ov4),  32'd0);
    chk("rst_perr1",     32'(pe1),  32'd0);
    rst_n = 1;

    // A5 has four ones: even.
    send(0, 8'hA5, 0, 1'b0, 1, 0);
    chk("shift_busy1",     32'(bz1), 32'd1);
    chk("shift_in_ready1", 32'(ir1), 32'd0);
    drain();

    // 07 has three ones; input churn during SHIFT must not matter.
    send(0, 8'h07, 0, 1'b1, 1, 0);
    iv1 = 1; id1 = 8'hFF;
    repeat (3) @(negedge clk);
    iv1 = 0;
    drain();

    // Four lanes: FE (seven ones) then 00.
    send(1, 8'hFE, 0, 1'b1, 1, 0);
    drain();
    send(1, 8'h00, 0, 1'b0, 1, 0);
    drain();

    // Backpressure with in_valid held high.
    or1 = 0;
    send(0, 8'h80, 0, 1'b1, 1, 1);
    id1 = 8'h01;
    n = 0;
    while (!ov1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(ov1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid",    32'(ov1),  32'd1);
      chk("bp_xor",      32'(ox1),  32'd1);
      chk("bp_xnor",     32'(oxn1), 32'd0);
      chk("bp_in_ready", 32'(ir1),  32'd0);
    end
    or1 = 1;
    send(0, 8'h01, 0, 1'b1, 1, 0);
    drain();

    // Abort mid-SHIFT: result discarded, next word unaffected.
    send(0, 8'hFF, 0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_in_ready", 32'(ir1),  32'd1);
    chk("abort_valid",    32'(ov1),  32'd0);
    chk("abort_xor",      32'(ox1),  32'd0);
    chk("abort_xnor",     32'(oxn1), 32'd1);
    chk("abort_busy",     32'(bz1),  32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    send(0, 8'h01, 0, 1'b1, 1, 0);
    drain();

`ifdef DEMUX_PARITY_CHECK_EN
    send(0, 8'hA5, 1, 1'b0, 1, 0);
    drain();
    send(0, 8'hA5, 0, 1'b0, 1, 0);
    drain();
`endif

    chk("queues_empty", 32'(q1.size() + q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
